// File: rtl/seven_seg_scan_pkg.sv
// Shared constants and slot-state encoding for the seven-segment scan path.
// Polarities are active-low throughout: an all-ones value means dark.
package seven_seg_scan_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] AN_OFF    = 4'b1111;
    localparam logic       SEL_MIN   = 1'b0;
    localparam logic       SEL_SEC   = 1'b1;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/seven_seg_scan_tick_gen.sv
// Free-running modulo-DIV counter with a one-cycle terminal-count pulse.
// The count is held at zero whenever en is low, so re-enabling starts a fresh period.
module tick_gen #(
    parameter int DIV = 2,
    parameter int CW  = $clog2(DIV)
) (
    input  logic          clk,
    input  logic          RESET,
    input  logic          en,
    output logic          tick,
    output logic [CW-1:0] cnt
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = en && (cnt_q == CW'(DIV - 1));
        cnt_d = cnt_q + CW'(1);
        if (!en || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit time-multiplexed seven-segment driver with per-frame snapshot,
// inter-digit blanking and adjust-mode blinking of the minutes or seconds pair.
//
//   state    | meaning
//   ST_BLANK | all anodes off, cathodes blank (lead-in, blink-off or no snapshot yet)
//   ST_SHOW  | anode idx on, cathodes carry snapshot[idx]
module seven_seg_scan
    import seven_seg_scan_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int BLINK_DIV    = 25000000
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic [7:0] digit0_display,
    input  logic [7:0] digit1_display,
    input  logic [7:0] digit2_display,
    input  logic [7:0] digit3_display,
    input  logic       adj,
    input  logic       sel,
    output logic [7:0] seg,
    output logic [3:0] an
);

    localparam int SW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_DIV);

    logic          slot_tick;
    logic [SW-1:0] slot_cnt;
    logic          blink_tick;
    logic [BW-1:0] blink_cnt_unused;

    logic [1:0]       idx_q, idx_d;
    logic [3:0][7:0]  snap_q, snap_d;
    logic             snap_vld_q, snap_vld_d;
    logic             sel_slot_q, sel_slot_d;
    logic             blink_phase_q, blink_phase_d;
    logic [7:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;

    logic             in_blank;
    logic             in_pair;
    logic             suppress;
    slot_state_t      slot_state;

    tick_gen #(.DIV(REFRESH_DIV), .CW(SW)) u_slot_timer (
        .clk   (clk),
        .RESET (RESET),
        .en    (1'b1),
        .tick  (slot_tick),
        .cnt   (slot_cnt)
    );

    tick_gen #(.DIV(BLINK_DIV), .CW(BW)) u_blink_timer (
        .clk   (clk),
        .RESET (RESET),
        .en    (adj),
        .tick  (blink_tick),
        .cnt   (blink_cnt_unused)
    );

    always_comb begin
        idx_d         = idx_q;
        snap_d        = snap_q;
        snap_vld_d    = snap_vld_q;
        sel_slot_d    = sel_slot_q;
        blink_phase_d = blink_phase_q;

        if (slot_tick) begin
            idx_d      = idx_q + 2'd1;
            sel_slot_d = sel;
            if (idx_q == 2'd3) begin
                snap_d     = {digit3_display, digit2_display, digit1_display, digit0_display};
                snap_vld_d = 1'b1;
            end
        end

        if (!adj) begin
            blink_phase_d = 1'b0;
        end else if (blink_tick) begin
            blink_phase_d = ~blink_phase_q;
        end
    end

    // Pair selection is latched per slot so a sel change never cuts a digit mid-slot.
    always_comb begin
        in_blank   = 32'(slot_cnt) < 32'(BLANK_CYCLES);
        in_pair    = (sel_slot_q == SEL_SEC) ? !idx_q[1] : idx_q[1];
        suppress   = adj && blink_phase_q && in_pair;
        slot_state = (in_blank || suppress || !snap_vld_q) ? ST_BLANK : ST_SHOW;

        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        if (slot_state == ST_SHOW) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = snap_q[idx_q];
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            idx_q         <= 2'd0;
            snap_q        <= {4{SEG_BLANK}};
            snap_vld_q    <= 1'b0;
            sel_slot_q    <= SEL_MIN;
            blink_phase_q <= 1'b0;
            seg_q         <= SEG_BLANK;
            an_q          <= AN_OFF;
        end else begin
            idx_q         <= idx_d;
            snap_q        <= snap_d;
            snap_vld_q    <= snap_vld_d;
            sel_slot_q    <= sel_slot_d;
            blink_phase_q <= blink_phase_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule
